// File: rtl/remote_key_queue_if.sv
// remote_key_queue_if: key event handshake between the key queue and the game FSM
// Signals:
//   key_valid  head entry presented (queue non-empty)
//   key_color  head colour, 0 green, 1 red, 2 yellow, 3 blue
//   key_start  head entry is START
//   key_ready  game FSM accepts the head entry
// Modports: master = queue side, slave = game FSM side.
interface remote_key_queue_if;
    logic       key_valid;
    logic [1:0] key_color;
    logic       key_start;
    logic       key_ready;
    modport master (output key_valid, key_color, key_start, input key_ready);
    modport slave  (input key_valid, key_color, key_start, output key_ready);
endinterface

// File: rtl/remote_key_queue.sv
// remote_key_queue: turns IR decoder frames into clean key events queued for the game FSM
// Ports:
//   clk           system clock, posedge
//   rst           asynchronous active-high reset
//   i_rdy_in      decoder frame-ready level; rising edge marks a frame
//   i_buttons_in  decoder 3-bit code, stable while i_rdy_in is high
//   key_if        key handshake (master side): valid/colour/start out, ready in
//   o_fifo_full   occupancy equals DEPTH
//   o_overflow    sticky, set when an accepted event is lost to a full FIFO
// Parameters: DEPTH (power of 2, >= 2), HOLDOFF (repeat window in cycles, >= 1).
// Build option: define KEY_HOLDOFF_EN to suppress repeats of the same code
// within HOLDOFF cycles; without it every valid-code event is queued.
module remote_key_queue #(
    parameter int DEPTH   = 4,
    parameter int HOLDOFF = 25_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_rdy_in,
    input  logic [2:0]            i_buttons_in,
    remote_key_queue_if.master    key_if,
    output logic                  o_fifo_full,
    output logic                  o_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and at least 2");
    end
    if (HOLDOFF < 1) begin : g_bad_holdoff
        $error("HOLDOFF must be at least 1");
    end

    logic          r_rdy_q;
    logic [2:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_event;
    logic          w_code_ok;
    logic [2:0]    w_entry;
    logic          w_cand;
    logic          w_pop;
    logic          w_push;
    logic [2:0]    w_head;

    assign w_event = i_rdy_in & ~r_rdy_q;

    // Entry is {start, colour}; unmatched codes (including X/Z) fall to default and are dropped.
    always_comb begin
        w_code_ok = 1'b1;
        w_entry   = 3'b000;
        case (i_buttons_in)
            3'b001:  w_entry = 3'b000;
            3'b010:  w_entry = 3'b001;
            3'b011:  w_entry = 3'b010;
            3'b110:  w_entry = 3'b011;
            3'b100:  w_entry = 3'b100;
            default: w_code_ok = 1'b0;
        endcase
    end

`ifdef KEY_HOLDOFF_EN
    localparam int HW = $clog2(HOLDOFF + 1);
    logic [2:0]    r_last_code;
    logic [HW-1:0] r_hold_cnt;

    // Only a repeat of the most recent code inside the window is suppressed;
    // a suppressed repeat leaves the window running rather than extending it.
    assign w_cand = w_event & w_code_ok & ~((i_buttons_in == r_last_code) && (r_hold_cnt != '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_code <= 3'b000;
            r_hold_cnt  <= '0;
        end else if (w_cand) begin
            r_last_code <= i_buttons_in;
            r_hold_cnt  <= HW'(HOLDOFF);
        end else if (r_hold_cnt != '0) begin
            r_hold_cnt  <= r_hold_cnt - 1'b1;
        end
    end
`else
    assign w_cand = w_event & w_code_ok;
`endif

    assign w_pop  = key_if.key_valid & key_if.key_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push = w_cand & ((r_count != L_FULL) | w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdy_q    <= 1'b1;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            o_overflow <= 1'b0;
        end else begin
            r_rdy_q <= i_rdy_in;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push & ~w_pop) r_count <= r_count + 1'b1;
            else if (w_pop & ~w_push) r_count <= r_count - 1'b1;
            if (w_cand & ~w_push) o_overflow <= 1'b1;
        end
    end

    // Storage needs no reset: the count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_entry;
    end

    assign w_head            = r_mem[r_rd_ptr];
    assign key_if.key_valid  = (r_count != '0);
    assign key_if.key_start  = key_if.key_valid & w_head[2];
    assign key_if.key_color  = (key_if.key_valid & ~w_head[2]) ? w_head[1:0] : 2'b00;
    assign o_fifo_full       = (r_count == L_FULL);
endmodule

// File: tb/tb_remote_key_queue.sv
// tb_remote_key_queue: directed self-checking bench for remote_key_queue (DEPTH=4, HOLDOFF=8)
// Expectations for repeat suppression follow KEY_HOLDOFF_EN as compiled.
module tb_remote_key_queue;
    logic       clk = 1'b0;
    logic       rst;
    logic       rdy_in;
    logic [2:0] buttons_in;
    logic       fifo_full;
    logic       overflow;
    int         n_pass = 0;
    int         n_total = 0;
    logic [2:0] got [16];
    int         n_got;

    remote_key_queue_if kif ();

    remote_key_queue #(.DEPTH(4), .HOLDOFF(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_rdy_in     (rdy_in),
        .i_buttons_in (buttons_in),
        .key_if       (kif),
        .o_fifo_full  (fifo_full),
        .o_overflow   (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [2:0] enc(input logic [2:0] c);
        case (c)
            3'b001:  return 3'b000;
            3'b010:  return 3'b001;
            3'b011:  return 3'b010;
            3'b110:  return 3'b011;
            default: return 3'b100;
        endcase
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // rdy_in high for one cycle starting at a negedge; the event is seen on the next posedge.
    task automatic pulse(input logic [2:0] c);
        rdy_in = 1'b1;
        buttons_in = c;
        @(negedge clk);
        rdy_in = 1'b0;
    endtask

    task automatic do_reset();
        rdy_in = 1'b0;
        buttons_in = 3'b000;
        kif.key_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Pops everything, recording {start, colour} of each entry seen.
    task automatic drain();
        n_got = 0;
        kif.key_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (!kif.key_valid) break;
            got[n_got] = {kif.key_start, kif.key_color};
            n_got++;
            @(negedge clk);
        end
        kif.key_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rdy_in = 1'b0;
        buttons_in = 3'b000;
        kif.key_ready = 1'b0;
        #1;
        n_total++; if (kif.key_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", kif.key_valid); else n_pass++;
        n_total++; if (kif.key_color !== 2'd0) $display("FAIL reset_color got %0d want 0", kif.key_color); else n_pass++;
        n_total++; if (kif.key_start !== 1'b0) $display("FAIL reset_start got %b want 0", kif.key_start); else n_pass++;
        n_total++; if (fifo_full !== 1'b0) $display("FAIL reset_full got %b want 0", fifo_full); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else n_pass++;
        do_reset();
        n_total++; if (kif.key_valid !== 1'b0) $display("FAIL reset_idle_valid got %b want 0", kif.key_valid); else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        kif.key_ready = 1'b1;
        pulse(3'b011);
        n_total++; if (kif.key_valid !== 1'b1) $display("FAIL single_valid got %b want 1", kif.key_valid); else n_pass++;
        n_total++; if (kif.key_color !== 2'd2) $display("FAIL single_color got %0d want 2", kif.key_color); else n_pass++;
        n_total++; if (kif.key_start !== 1'b0) $display("FAIL single_start got %b want 0", kif.key_start); else n_pass++;
        tick(1);
        n_total++; if (kif.key_valid !== 1'b0) $display("FAIL single_popped got %b want 0", kif.key_valid); else n_pass++;
        tick(2);
        n_total++; if (kif.key_valid !== 1'b0) $display("FAIL single_empty got %b want 0", kif.key_valid); else n_pass++;
        kif.key_ready = 1'b0;
    endtask

    task automatic test_invalid();
        logic [2:0] bad [3];
        bad = '{3'b000, 3'b101, 3'b111};
        do_reset();
        kif.key_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pulse(bad[i]);
            n_total++; if (kif.key_valid !== 1'b0) $display("FAIL invalid_valid code=%b got %b want 0", bad[i], kif.key_valid); else n_pass++;
            n_total++; if (overflow !== 1'b0) $display("FAIL invalid_overflow code=%b got %b want 0", bad[i], overflow); else n_pass++;
            tick(1);
        end
        pulse(3'b100);
        n_total++; if (kif.key_valid !== 1'b1) $display("FAIL start_valid got %b want 1", kif.key_valid); else n_pass++;
        n_total++; if (kif.key_start !== 1'b1) $display("FAIL start_flag got %b want 1", kif.key_start); else n_pass++;
        n_total++; if (kif.key_color !== 2'd0) $display("FAIL start_color got %0d want 0", kif.key_color); else n_pass++;
        tick(1);
        kif.key_ready = 1'b0;
    endtask

    task automatic test_holdoff();
        int exp_a, exp_b;
`ifdef KEY_HOLDOFF_EN
        exp_a = 2;
        exp_b = 1;
`else
        exp_a = 3;
        exp_b = 2;
`endif
        // 001 at events 1, 4 and 11
        do_reset();
        pulse(3'b001); tick(2); pulse(3'b001); tick(6); pulse(3'b001); tick(1);
        drain();
        n_total++; if (n_got !== exp_a) $display("FAIL holdoff_repeat entries got %0d want %0d", n_got, exp_a); else n_pass++;
        // repeat 8 cycles later: one cycle of the window still left
        do_reset();
        pulse(3'b001); tick(7); pulse(3'b001); tick(1);
        drain();
        n_total++; if (n_got !== exp_b) $display("FAIL holdoff_edge_in entries got %0d want %0d", n_got, exp_b); else n_pass++;
        // repeat 9 cycles later: window just expired
        do_reset();
        pulse(3'b001); tick(8); pulse(3'b001); tick(1);
        drain();
        n_total++; if (n_got !== 2) $display("FAIL holdoff_edge_out entries got %0d want 2", n_got); else n_pass++;
        // different codes back-to-back
        do_reset();
        pulse(3'b001); tick(1); pulse(3'b010); tick(1);
        drain();
        n_total++; if (n_got !== 2) $display("FAIL b2b_count got %0d want 2", n_got); else n_pass++;
        n_total++; if (got[0] !== 3'b000) $display("FAIL b2b_first got %b want 000", got[0]); else n_pass++;
        n_total++; if (got[1] !== 3'b001) $display("FAIL b2b_second got %b want 001", got[1]); else n_pass++;
    endtask

    task automatic test_overflow();
        logic exp_ov;
`ifdef KEY_HOLDOFF_EN
        exp_ov = 1'b0;
`else
        exp_ov = 1'b1;
`endif
        do_reset();
        pulse(3'b001); tick(1); pulse(3'b010); tick(1); pulse(3'b011);
        n_total++; if (fifo_full !== 1'b0) $display("FAIL ovf_three_full got %b want 0", fifo_full); else n_pass++;
        tick(1); pulse(3'b110);
        n_total++; if (fifo_full !== 1'b1) $display("FAIL ovf_four_full got %b want 1", fifo_full); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL ovf_four_flag got %b want 0", overflow); else n_pass++;
        n_total++; if (kif.key_color !== 2'd0) $display("FAIL ovf_head_color got %0d want 0", kif.key_color); else n_pass++;
        // repeat of the last code inside the window, FIFO full
        tick(1); pulse(3'b110);
        n_total++; if (overflow !== exp_ov) $display("FAIL ovf_repeat_flag got %b want %b", overflow, exp_ov); else n_pass++;
        tick(1); pulse(3'b100);
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_fifth_flag got %b want 1", overflow); else n_pass++;
        n_total++; if (fifo_full !== 1'b1) $display("FAIL ovf_fifth_full got %b want 1", fifo_full); else n_pass++;
        tick(1);
        drain();
        n_total++; if (n_got !== 4) $display("FAIL ovf_drain_count got %0d want 4", n_got); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++; if (got[i] !== 3'(i)) $display("FAIL ovf_order[%0d] got %b want %b", i, got[i], 3'(i)); else n_pass++;
        end
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b want 1", overflow); else n_pass++;
        n_total++; if (fifo_full !== 1'b0) $display("FAIL ovf_drained_full got %b want 0", fifo_full); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [2:0] codes [5];
        logic [2:0] exp_q [$];
        logic [2:0] c;
        codes = '{3'b100, 3'b001, 3'b010, 3'b011, 3'b110};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pulse(codes[i+1]);
            exp_q.push_back(enc(codes[i+1]));
            tick(1);
        end
        n_total++; if (fifo_full !== 1'b1) $display("FAIL rot_filled got %b want 1", fifo_full); else n_pass++;
        // three full pointer rotations of simultaneous push and pop
        for (int i = 0; i < 12; i++) begin
            c = codes[i % 5];
            n_total++; if ({kif.key_start, kif.key_color} !== exp_q[0]) $display("FAIL rot_head[%0d] got %b want %b", i, {kif.key_start, kif.key_color}, exp_q[0]); else n_pass++;
            kif.key_ready = 1'b1;
            rdy_in = 1'b1;
            buttons_in = c;
            @(negedge clk);
            rdy_in = 1'b0;
            kif.key_ready = 1'b0;
            void'(exp_q.pop_front());
            exp_q.push_back(enc(c));
            n_total++; if (fifo_full !== 1'b1) $display("FAIL rot_full[%0d] got %b want 1", i, fifo_full); else n_pass++;
            n_total++; if (overflow !== 1'b0) $display("FAIL rot_overflow[%0d] got %b want 0", i, overflow); else n_pass++;
            tick(1);
        end
        drain();
        n_total++; if (n_got !== 4) $display("FAIL rot_drain_count got %0d want 4", n_got); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++; if (got[i] !== exp_q[i]) $display("FAIL rot_tail[%0d] got %b want %b", i, got[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_reset_cases();
        // rdy_in already high when reset releases
        rdy_in = 1'b1;
        buttons_in = 3'b001;
        kif.key_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick(3);
        n_total++; if (kif.key_valid !== 1'b0) $display("FAIL rst_high_rdy got %b want 0", kif.key_valid); else n_pass++;
        rdy_in = 1'b0;
        // asynchronous clear with entries queued
        do_reset();
        pulse(3'b001); tick(1); pulse(3'b010); tick(1); pulse(3'b011);
        n_total++; if (kif.key_valid !== 1'b1) $display("FAIL rst_queued got %b want 1", kif.key_valid); else n_pass++;
        rst = 1'b1;
        #1;
        n_total++; if (kif.key_valid !== 1'b0) $display("FAIL rst_async_valid got %b want 0", kif.key_valid); else n_pass++;
        n_total++; if (kif.key_color !== 2'd0) $display("FAIL rst_async_color got %0d want 0", kif.key_color); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        tick(2);
        n_total++; if (kif.key_valid !== 1'b0) $display("FAIL rst_after_valid got %b want 0", kif.key_valid); else n_pass++;
        // identical repeat 3 cycles apart
        do_reset();
        pulse(3'b001); tick(2); pulse(3'b001); tick(1);
        drain();
`ifdef KEY_HOLDOFF_EN
        n_total++; if (n_got !== 1) $display("FAIL repeat3_entries got %0d want 1", n_got); else n_pass++;
`else
        n_total++; if (n_got !== 2) $display("FAIL repeat3_entries got %0d want 2", n_got); else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_invalid();
        test_holdoff();
        test_overflow();
        test_back_to_back();
        test_reset_cases();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
